// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the 32x32 register file (ALU vs. load writeback) plus a
// pending-write scoreboard that the issue stage queries for RAW hazards.
module regfile_wb_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [4:0]  req0_rw,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_rw,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  input  logic        rsv_valid,
  input  logic [4:0]  rsv_rw,
  input  logic [4:0]  qa,
  input  logic [4:0]  qb,
  output logic        qa_busy,
  output logic        qb_busy,
  output logic [31:0] busy,
  output logic        rf_we,
  output logic [4:0]  rf_rw,
  output logic [31:0] rf_busw
);

  localparam logic [3:0] MaxWaitC = 4'(MAX_WAIT);

  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_rw_q, rf_rw_d;
  logic [31:0] rf_busw_q, rf_busw_d;
  logic [31:0] busy_q, busy_d;

  logic        starved;
  logic        gnt0, gnt1, any_gnt;
  logic [4:0]  sel_rw;
  logic [31:0] sel_data;

  // Load data cannot be replayed, so port 1 wins unless port 0 has starved.
  always_comb begin
    starved = req0_valid && req1_valid && (wait_cnt_q == MaxWaitC);
    gnt1    = req1_valid && !starved;
    gnt0    = req0_valid && !gnt1;
    any_gnt = gnt0 || gnt1;
  end

  assign req0_ready = gnt0 && reset;
  assign req1_ready = gnt1 && reset;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!req0_valid || gnt0) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q < MaxWaitC) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_comb begin
    sel_rw    = gnt1 ? req1_rw   : req0_rw;
    sel_data  = gnt1 ? req1_data : req0_data;
    rf_we_d   = any_gnt && (sel_rw != 5'd0);
    rf_rw_d   = any_gnt ? sel_rw   : rf_rw_q;
    rf_busw_d = any_gnt ? sel_data : rf_busw_q;
  end

  // Set is applied after clear so a fresh reservation survives a same-edge commit.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q) begin
      busy_d[rf_rw_q] = 1'b0;
    end
    if (rsv_valid && (rsv_rw != 5'd0)) begin
      busy_d[rsv_rw] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= 4'd0;
      rf_we_q    <= 1'b0;
      rf_rw_q    <= 5'd0;
      rf_busw_q  <= 32'd0;
      busy_q     <= 32'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rf_we_q    <= rf_we_d;
      rf_rw_q    <= rf_rw_d;
      rf_busw_q  <= rf_busw_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_we   = rf_we_q;
  assign rf_rw   = rf_rw_q;
  assign rf_busw = rf_busw_q;
  assign busy    = busy_q;
  assign qa_busy = busy_q[qa];
  assign qb_busy = busy_q[qb];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a rule-level model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_regfile_wb_arbiter;

  localparam int MAXW = 4;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid, rsv_valid;
  logic [4:0]  req0_rw, req1_rw, rsv_rw, qa, qb;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready, qa_busy, qb_busy, rf_we;
  logic [4:0]  rf_rw;
  logic [31:0] rf_busw, busy;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_wb_arbiter #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_data(req1_data), .req1_ready(req1_ready),
    .rsv_valid(rsv_valid), .rsv_rw(rsv_rw), .qa(qa), .qb(qb),
    .qa_busy(qa_busy), .qb_busy(qb_busy), .busy(busy),
    .rf_we(rf_we), .rf_rw(rf_rw), .rf_busw(rf_busw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Model state: the write seen on the regfile port, the set of pending
  // registers, and how many cycles in a row the ALU request has lost.
  bit        m_we;
  bit [4:0]  m_rw;
  bit [31:0] m_data;
  bit [31:0] m_busy;
  int        m_streak;

  // 0 = nobody, 1 = ALU port, 2 = memory port
  function automatic int who_wins(input bit v0, input bit v1, input int streak);
    if (v0 && v1) return (streak >= MAXW) ? 1 : 2;
    if (v1) return 2;
    if (v0) return 1;
    return 0;
  endfunction

  function automatic bit [31:0] next_busy(input bit [31:0] cur, input bit we, input bit [4:0] rw,
                                          input bit rv, input bit [4:0] rr);
    bit [31:0] b;
    b = cur;
    if (we) b[rw] = 1'b0;
    if (rv && rr != 0) b[rr] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  function automatic int next_streak(input bit v0, input int w, input int streak);
    if (!v0 || w == 1) return 0;
    return (streak + 1 > MAXW) ? MAXW : streak + 1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_we <= 0; m_rw <= 0; m_data <= 0; m_busy <= 0; m_streak <= 0;
    end else begin
      m_busy   <= next_busy(m_busy, m_we, m_rw, rsv_valid, rsv_rw);
      m_streak <= next_streak(req0_valid, who_wins(req0_valid, req1_valid, m_streak), m_streak);
      case (who_wins(req0_valid, req1_valid, m_streak))
        1: begin m_we <= (req0_rw != 0); m_rw <= req0_rw; m_data <= req0_data; end
        2: begin m_we <= (req1_rw != 0); m_rw <= req1_rw; m_data <= req1_data; end
        default: m_we <= 0;
      endcase
    end
  end

  // Compare just before each rising edge, when inputs and outputs are settled.
  always @(negedge clk) begin
    int w;
    #4;
    w = reset ? who_wins(req0_valid, req1_valid, m_streak) : 0;
    chk("m_ready0", {31'd0, req0_ready}, {31'd0, w == 1});
    chk("m_ready1", {31'd0, req1_ready}, {31'd0, w == 2});
    chk("m_rf_we",  {31'd0, rf_we}, {31'd0, m_we});
    chk("m_rf_rw",  {27'd0, rf_rw}, {27'd0, m_rw});
    chk("m_rf_busw", rf_busw, m_data);
    chk("m_busy",   busy, m_busy);
    chk("m_qa_busy", {31'd0, qa_busy}, {31'd0, m_busy[qa]});
    chk("m_qb_busy", {31'd0, qb_busy}, {31'd0, m_busy[qb]});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int exp_seq [10];
    exp_seq = '{3, 3, 3, 3, 2, 3, 3, 3, 3, 2};
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0; rsv_valid = 0;
    req0_rw = 0; req1_rw = 0; rsv_rw = 0; qa = 0; qb = 0;
    req0_data = 0; req1_data = 0;
    #1 reset = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
    #1;
    chk("reset_we", {31'd0, rf_we}, 32'd0);
    chk("reset_busy", busy, 32'd0);

    // Single ALU write
    req0_valid = 1; req0_rw = 5'd5; req0_data = 32'hDEAD_BEEF;
    #1 chk("single_ready0", {31'd0, req0_ready}, 32'd1);
    cyc();
    req0_valid = 0;
    chk("single_we", {31'd0, rf_we}, 32'd1);
    chk("single_rw", {27'd0, rf_rw}, 32'd5);
    chk("single_busw", rf_busw, 32'hDEAD_BEEF);
    cyc();
    chk("single_we_off", {31'd0, rf_we}, 32'd0);

    // Both ports continuously valid: 4 memory grants, then one ALU grant
    req0_valid = 1; req0_rw = 5'd2; req0_data = 32'hA0A0_0002;
    req1_valid = 1; req1_rw = 5'd3; req1_data = 32'hB0B0_0003;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk($sformatf("starve_rw%0d", i), {27'd0, rf_rw}, 32'(exp_seq[i]));
    end
    req0_valid = 0; req1_valid = 0;
    cyc();

    // Write to r0: accepted, but no register file write
    req1_valid = 1; req1_rw = 5'd0; req1_data = 32'h0000_1234;
    #1 chk("r0_ready1", {31'd0, req1_ready}, 32'd1);
    cyc();
    req1_valid = 0;
    chk("r0_we", {31'd0, rf_we}, 32'd0);
    chk("r0_busy", busy, 32'd0);

    // Scoreboard set and clear on commit
    rsv_valid = 1; rsv_rw = 5'd7; qa = 5'd7; qb = 5'd3;
    #1 chk("rsv_no_bypass", {31'd0, qa_busy}, 32'd0);
    cyc();
    rsv_valid = 0;
    chk("rsv_qa_busy", {31'd0, qa_busy}, 32'd1);
    chk("rsv_qb_idle", {31'd0, qb_busy}, 32'd0);
    chk("rsv_busy", busy, 32'h0000_0080);
    req0_valid = 1; req0_rw = 5'd7; req0_data = 32'h7777_0007;
    cyc();
    req0_valid = 0;
    chk("sb_we", {31'd0, rf_we}, 32'd1);
    chk("sb_busy_held", busy, 32'h0000_0080);
    cyc();
    chk("sb_busy_clr", busy, 32'd0);
    chk("sb_qa_clr", {31'd0, qa_busy}, 32'd0);

    // Collision: reserve r7 on the edge that commits r7
    rsv_valid = 1; rsv_rw = 5'd7;
    cyc();
    rsv_valid = 0;
    req0_valid = 1; req0_rw = 5'd7; req0_data = 32'h0000_0077;
    cyc();
    req0_valid = 0;
    chk("coll_we", {31'd0, rf_we}, 32'd1);
    rsv_valid = 1; rsv_rw = 5'd7;
    cyc();
    rsv_valid = 0;
    chk("coll_busy", busy, 32'h0000_0080);
    req0_valid = 1; req0_rw = 5'd7;
    cyc();
    req0_valid = 0;
    cyc();
    chk("coll_drain", busy, 32'd0);

    // Asynchronous reset mid-stream
    rsv_valid = 1; rsv_rw = 5'd1;
    cyc();
    rsv_rw = 5'd2;
    req0_valid = 1; req0_rw = 5'd9; req0_data = 32'h9999_0009;
    cyc();
    rsv_valid = 0;
    req1_valid = 1; req1_rw = 5'd4; req1_data = 32'h4444_0004;
    chk("pre_rst_we", {31'd0, rf_we}, 32'd1);
    chk("pre_rst_busy", busy, 32'h0000_0006);
    #2 reset = 1'b0;
    #1;
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_rw", {27'd0, rf_rw}, 32'd0);
    chk("rst_busw", rf_busw, 32'd0);
    chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
    cyc();
    reset = 1'b1;
    #1;
    chk("post_rst_ready1", {31'd0, req1_ready}, 32'd1);
    chk("post_rst_ready0", {31'd0, req0_ready}, 32'd0);
    cyc();
    req0_valid = 0; req1_valid = 0;
    chk("post_rst_rw", {27'd0, rf_rw}, 32'd4);
    chk("post_rst_busw", rf_busw, 32'h4444_0004);
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
